// File: rtl/rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } rca_op_e;

    // Bits per carry-chain segment.
    function automatic int unsigned rca_seg_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple segment built from fa cells.
module rca_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        fa u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[SEG];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH-bit chain cut into STAGES registered
// segments, exact (WIDTH+1)-bit result, valid/ready handshake with one global enable.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s
);

    localparam int unsigned SEG = rca_seg_w(WIDTH, STAGES);
    localparam int unsigned XW  = WIDTH + 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
        $error("rca_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Index k is the input side of stage k; index k+1 is its registered output.
    logic [XW-1:0] a_p [STAGES];
    logic [XW-1:0] b_p [STAGES];
    logic          c_p [STAGES];
    logic [XW-1:0] s_p [STAGES+1];
    logic          v_p [STAGES+1];

    rca_op_e op_e;
    logic    sub;
    logic    adv;

    assign op_e = rca_op_e'(op);
    assign sub  = (op_e == OP_SUB);

    // B is inverted once at entry; op lives on as the stage-0 carry-in.
    assign a_p[0] = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
    assign b_p[0] = ((SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b}) ^ {XW{sub}};
    assign c_p[0] = sub;
    assign s_p[0] = '0;
    assign v_p[0] = in_valid;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_p[STAGES];
    assign s         = s_p[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SEG;

        logic [SEG-1:0] seg_s;
        logic           seg_c;
        logic [XW-1:0]  s_nxt;
        logic [XW-1:0]  s_q;
        logic           v_q;

        rca_seg #(.SEG(SEG)) u_seg (
            .a   (a_p[k][LO +: SEG]),
            .b   (b_p[k][LO +: SEG]),
            .cin (c_p[k]),
            .s   (seg_s),
            .cout(seg_c)
        );

        if (k == STAGES - 1) begin : g_last
            // Final stage also resolves the extension bit.
            always_comb begin
                s_nxt            = s_p[k];
                s_nxt[LO +: SEG] = seg_s;
                s_nxt[WIDTH]     = a_p[k][WIDTH] ^ b_p[k][WIDTH] ^ seg_c;
            end
        end else begin : g_mid
            logic [XW-1:0] a_q;
            logic [XW-1:0] b_q;
            logic          c_q;

            always_comb begin
                s_nxt            = s_p[k];
                s_nxt[LO +: SEG] = seg_s;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_p[k];
                    b_q <= b_p[k];
                    c_q <= seg_c;
                end
            end

            assign a_p[k+1] = a_q;
            assign b_p[k+1] = b_q;
            assign c_p[k+1] = c_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_nxt;
                v_q <= v_p[k];
            end
        end

        assign s_p[k+1] = s_q;
        assign v_p[k+1] = v_q;
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench: four rca_pipe configurations driven in parallel, each checked
// against a plain-arithmetic reference queue on every output beat.
module tb_rca_pipe;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;

    logic        ov [N];
    logic        ir [N];
    logic [16:0] sv [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(16), .STAGES(4), .SIGNED(0)) u_u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
        .out_valid(ov[0]), .out_ready(out_ready), .s(sv[0]));
    rca_pipe #(.WIDTH(16), .STAGES(4), .SIGNED(1)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
        .out_valid(ov[1]), .out_ready(out_ready), .s(sv[1]));
    rca_pipe #(.WIDTH(16), .STAGES(1), .SIGNED(0)) u_u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
        .out_valid(ov[2]), .out_ready(out_ready), .s(sv[2]));
    rca_pipe #(.WIDTH(16), .STAGES(16), .SIGNED(0)) u_u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .op(op),
        .out_valid(ov[3]), .out_ready(out_ready), .s(sv[3]));

    function automatic int stg(input int i);
        case (i)
            2:       return 1;
            3:       return 16;
            default: return 4;
        endcase
    endfunction

    // Reference: exact integer add/sub of the operand values, kept to 17 bits.
    function automatic logic [16:0] ref_sum(input bit sgn, input logic [15:0] x,
                                            input logic [15:0] y, input logic o);
        longint ex;
        longint ey;
        longint r;
        ex = sgn ? longint'($signed(x)) : longint'(x);
        ey = sgn ? longint'($signed(y)) : longint'(y);
        r  = o ? (ex - ey) : (ex + ey);
        return r[16:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic [16:0] q [N][$];
    bit          post_rst [N];
    bit          held_v [N];
    logic [16:0] held_s [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            post_rst[i] = 1'b0;
            held_v[i]   = 1'b0;
            held_s[i]   = '0;
        end
    end

    // Scoreboard: inputs change just after posedge, so negedge sees what the next edge samples.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (post_rst[i]) begin
                chk("rst_out_valid", 32'(ov[i]), 32'd0);
                chk("rst_s", 32'(sv[i]), 32'd0);
                chk("rst_in_ready", 32'(ir[i]), 32'd1);
                post_rst[i] = 1'b0;
            end
            if (held_v[i]) begin
                chk("stall_hold_valid", 32'(ov[i]), 32'd1);
                chk("stall_hold_s", 32'(sv[i]), 32'(held_s[i]));
            end
            held_v[i] = 1'b0;
            if (rst) begin
                q[i].delete();
                post_rst[i] = 1'b1;
            end else begin
                chk("in_ready", 32'(ir[i]), 32'(!ov[i] || out_ready));
                if (ov[i] && !out_ready) begin
                    held_v[i] = 1'b1;
                    held_s[i] = sv[i];
                end
                if (ov[i] && out_ready) begin
                    chk("beat_expected", 32'(q[i].size() > 0), 32'd1);
                    if (q[i].size() > 0) chk($sformatf("result_inst%0d", i), 32'(sv[i]), 32'(q[i].pop_front()));
                end
                if (in_valid && ir[i]) q[i].push_back(ref_sum(i == 1, a, b, op));
            end
        end
    end

    // One isolated beat with out_ready high; checks latency of every instance and a literal result.
    task automatic dir(input logic [15:0] x, input logic [15:0] y, input logic o,
                       input int idx, input logic [16:0] exp, input string nm);
        int          lat [N];
        logic [16:0] cap [N];
        for (int i = 0; i < N; i++) begin
            lat[i] = -1;
            cap[i] = 'x;
        end
        a = x; b = y; op = o; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (lat[i] < 0 && ov[i]) begin
                    lat[i] = c;
                    cap[i] = sv[i];
                end
            end
        end
        chk(nm, 32'(cap[idx]), 32'(exp));
        for (int i = 0; i < N; i++) chk($sformatf("latency_inst%0d", i), 32'(lat[i]), 32'(stg(i)));
        @(posedge clk); #2;
    endtask

    // Back-to-back random beats with a 3-cycle out_ready drop starting at cycle st_at.
    task automatic stream(input int nbeats, input int st_at);
        int acc = 0;
        int cyc = 0;
        bit saw_low = 1'b0;
        while (acc < nbeats && cyc < 200) begin
            a = 16'($urandom);
            b = 16'($urandom);
            op = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            out_ready = !(cyc >= st_at && cyc < st_at + 3);
            @(negedge clk);
            if (ir[0]) acc++;
            if (!out_ready && !ir[0]) saw_low = 1'b1;
            @(posedge clk); #2;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_drops_in_ready", 32'(saw_low), 32'd1);
        repeat (40) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) chk($sformatf("drained_inst%0d", i), 32'(q[i].size()), 32'd0);
    endtask

    initial begin
        chk("model_uadd", 32'(ref_sum(1'b0, 16'hFFFF, 16'h0001, 1'b0)), 32'h10000);
        chk("model_usub", 32'(ref_sum(1'b0, 16'h0000, 16'h0001, 1'b1)), 32'h1FFFF);
        chk("model_sadd", 32'(ref_sum(1'b1, 16'h8000, 16'h8000, 1'b0)), 32'h10000);
        chk("model_ssub", 32'(ref_sum(1'b1, 16'h8000, 16'h0001, 1'b1)), 32'h17FFF);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #2;

        dir(16'hFFFF, 16'h0001, 1'b0, 0, 17'h10000, "uadd_carry");
        dir(16'h1234, 16'h4321, 1'b0, 0, 17'h05555, "uadd_plain");
        dir(16'h0000, 16'h0001, 1'b1, 0, 17'h1FFFF, "usub_borrow");
        dir(16'h8000, 16'h0001, 1'b1, 0, 17'h07FFF, "usub_plain");
        dir(16'h8000, 16'h8000, 1'b0, 1, 17'h10000, "sadd_negmin");
        dir(16'h7FFF, 16'h0001, 1'b0, 1, 17'h08000, "sadd_posmax");
        dir(16'h8000, 16'h0001, 1'b1, 1, 17'h17FFF, "ssub_negmin");

        stream(8, 5);
        stream(24, 18);

        // Reset with three beats in flight; none of them may surface afterwards.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        dir(16'h00FF, 16'h0F01, 1'b0, 0, 17'h01000, "after_reset");

        // Random traffic, random back-pressure and occasional reset.
        for (int c = 0; c < 600; c++) begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            @(posedge clk); #2;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) chk($sformatf("final_drain_inst%0d", i), 32'(q[i].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
